// File: rtl/mult_div_unit_pkg.sv
// Shared EX-stage definitions: ALU op codes, MDU op codes, MDU latency defaults
// and a couple of op-class helpers used by the mult/div unit.
package mult_div_unit_pkg;

  // Default busy lengths, in cycles, for the mult/div unit
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLL = 4'b0111
  } alu_op_e;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'b0000,
    MDU_MULTU = 4'b0001,
    MDU_DIV   = 4'b0010,
    MDU_DIVU  = 4'b0011,
    MDU_MFHI  = 4'b0100,
    MDU_MFLO  = 4'b0101,
    MDU_MTHI  = 4'b0110,
    MDU_MTLO  = 4'b0111,
    MDU_NOP   = 4'b1111
  } mdu_op_e;

  // Ops that a start pulse may launch
  function automatic logic is_muldiv(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Mult/div unit operand and result bundle.
//   inA, inB : operands (rs, rt) from the EX forwarding mux
//   MDUctrl  : MDU op select
//   start    : one-cycle launch pulse for MULT/MULTU/DIV/DIVU
//   busy     : operation in flight
//   result   : MFHI/MFLO read data
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic [31:0] inA;
  logic [31:0] inB;
  mdu_op_e     MDUctrl;
  logic        start;
  logic        busy;
  logic [31:0] result;

  modport master (
    output inA, inB, MDUctrl, start,
    input  busy, result
  );

  modport slave (
    input  inA, inB, MDUctrl, start,
    output busy, result
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The full result is computed at the start edge and held in pending registers;
// HI/LO are only updated when the latency counter expires, so MFHI/MFLO always
// return committed values.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   mdu   : slave side of mult_div_unit_if (operands, op, start, busy, result)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  mdu
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          r_state;
  logic            r_busy;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_hi, r_lo;
  logic [31:0]     r_pend_hi, r_pend_lo;
  logic            r_pend_wr;

  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [63:0] w_bd_sx;
  logic [31:0] w_bd;
  logic        w_div_zero;
  logic [31:0] w_new_hi, w_new_lo;

  // Full-width result for the op presented with start
  always_comb begin
    w_a_sx     = {{32{mdu.inA[31]}}, mdu.inA};
    w_b_sx     = {{32{mdu.inB[31]}}, mdu.inB};
    w_a_zx     = {32'b0, mdu.inA};
    w_b_zx     = {32'b0, mdu.inB};
    w_div_zero = (mdu.inB == 32'd0);
    // Divisor forced non-zero; a zero-divide result is never committed anyway
    w_bd       = w_div_zero ? 32'd1 : mdu.inB;
    w_bd_sx    = {{32{w_bd[31]}}, w_bd};
    w_new_hi   = '0;
    w_new_lo   = '0;
    case (mdu.MDUctrl)
      MDU_MULT:  {w_new_hi, w_new_lo} = w_a_sx * w_b_sx;
      MDU_MULTU: {w_new_hi, w_new_lo} = w_a_zx * w_b_zx;
      MDU_DIV: begin
        // 64-bit signed divide so 0x80000000 / -1 wraps to 0x80000000
        w_new_lo = 32'($signed(w_a_sx) / $signed(w_bd_sx));
        w_new_hi = 32'($signed(w_a_sx) % $signed(w_bd_sx));
      end
      MDU_DIVU: begin
        w_new_lo = mdu.inA / w_bd;
        w_new_hi = mdu.inA % w_bd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (mdu.start && is_muldiv(mdu.MDUctrl)) begin
            r_pend_hi <= w_new_hi;
            r_pend_lo <= w_new_lo;
            r_pend_wr <= !(is_div(mdu.MDUctrl) && w_div_zero);
            // Counts down to zero; the edge after zero commits
            r_cnt     <= is_div(mdu.MDUctrl) ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
            r_busy    <= 1'b1;
            r_state   <= StBusy;
          end else if (mdu.MDUctrl == MDU_MTHI) begin
            r_hi <= mdu.inA;
          end else if (mdu.MDUctrl == MDU_MTLO) begin
            r_lo <= mdu.inA;
          end
        end
        StBusy: begin
          if (r_cnt == '0) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign mdu.busy = r_busy;

  always_comb begin
    mdu.result = '0;
    if (mdu.MDUctrl == MDU_MFHI) mdu.result = r_hi;
    else if (mdu.MDUctrl == MDU_MFLO) mdu.result = r_lo;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL be the number of cycles busy stays high for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL be the number of cycles busy stays high for DIV/DIVU.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 inA  input  32  SHALL be operand A, i.e. rs, from the same EX-stage forwarding mux that feeds the ALU.
REQ-006 inB  input  32  SHALL be operand B, i.e. rt, from the same forwarding mux.
REQ-007 MDUctrl  input  4  SHALL be the op select: NOP, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-008 start  input  1  SHALL be a one-cycle pulse launching MULT/MULTU/DIV/DIVU.
REQ-009 busy  output  1  SHALL be high while an operation is in flight.
REQ-010 result  output  32  SHALL be the MFHI/MFLO read data, muxed into the EX-stage result beside the ALU result.

Function
REQ-011 FSM SHALL have two states: IDLE and BUSY, plus a cycle counter and pending HI/LO holding registers.
REQ-012 In IDLE with start=1 and a mult/div MDUctrl, the unit SHALL latch the full result and the latency, then enter BUSY on that edge.
REQ-013 busy SHALL be 1 for exactly MULT_CYCLES or DIV_CYCLES cycles after the start edge.
REQ-014 On the edge that ends BUSY, the unit SHALL update HI/LO, drop busy to 0 and return to IDLE.
REQ-015 MULT SHALL use the signed 64-bit product and MULTU the unsigned one; HI is bits 63:32 and LO is bits 31:0.
REQ-016 DIV SHALL be signed, with the quotient truncated toward zero into LO and the remainder (sign of the dividend) into HI.
REQ-017 DIVU SHALL be unsigned: LO is the quotient and HI the remainder.
REQ-018 DIV 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-019 DIV or DIVU with inB=0 SHALL still run DIV_CYCLES, leaving HI and LO unchanged at completion.
REQ-020 start while busy=1 SHALL be ignored; the hazard unit stalls on (start | busy) together with an MDU-class instruction in ID.
REQ-021 MTHI/MTLO in IDLE SHALL write inA into HI/LO on the next edge, with no busy.
REQ-022 MTHI/MTLO while busy SHALL be ignored.
REQ-023 result SHALL be combinational: HI when MDUctrl=MFHI, LO when MDUctrl=MFLO, otherwise 0.
REQ-024 result SHALL show the committed HI/LO, never pending values; during BUSY it reflects pre-operation contents.
REQ-025 start with a non-mult/div MDUctrl SHALL be ignored.
REQ-026 start with MDUctrl=MTHI/MTLO SHALL act as MTHI/MTLO only.

Reset
REQ-027 Asserting reset (low) SHALL immediately clear HI, LO, the pending registers and the counter, force state IDLE and set busy to 0.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight result; after release, HI=LO=0.
REQ-029 Release of reset SHALL take effect at the next rising clk edge.

Structure
REQ-030 The MDUctrl encodings (MDU_NOP=4'b1111, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO) SHALL live in the shared definitions package beside the ALU_* codes.
REQ-031 MULT_CYCLES and DIV_CYCLES defaults SHALL also live in that package.
REQ-032 The block SHALL be a single module with no sub-module; the datapath uses behavioural * / % with a latency counter.

Verification
REQ-033 Scenario: MULT inA=0xFFFF0000, inB=0x7FFFFFFF, start pulse -> busy high 5 cycles; then HI=0xFFFF8000 and LO=0x00010000.
REQ-034 Scenario: MULTU with the same operands -> HI=0x7FFF7FFF and LO=0x00010000 after 5 cycles.
REQ-035 Scenario: DIV inA=0xFFFFFFF9 (-7), inB=2 -> busy high 10 cycles; then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-036 Scenario: DIVU 7/0 after MTHI 0x11, MTLO 0x22 -> HI=0x11 and LO=0x22 retained; a second start during busy leaves busy length unchanged.
REQ-037 Scenario: MFLO issued during a DIV -> result returns the old LO until busy falls, then the new LO.
REQ-038 Scenario: reset driven low at BUSY cycle 3 of a MULT -> busy=0 immediately; after release, MFHI=0 and MFLO=0.
